// File: rtl/fifo_uart_tx.sv
// UART transmitter that drains a byte FIFO one frame at a time.
// Frame: start, 8 data bits LSB-first, optional parity, 1 or 2 stop bits.
module fifo_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned PARITY_EN    = 0,
  parameter int unsigned PARITY_ODD   = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_en,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_data,
  output logic       fifo_rd_en,
  output logic       tx,
  output logic       busy,
  output logic       frame_done
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LOAD, S_START, S_DATA, S_PARITY, S_STOP
  } state_e;

  state_e           state_q;
  logic [CNT_W-1:0] baud_q;
  logic [2:0]       bit_q;
  logic             stop_q;
  logic [7:0]       shift_q;
  logic             par_q;
  logic             tx_q;
  logic             rd_q;
  logic             busy_q;
  logic             done_q;

  logic bit_end;
  logic done_next;
  logic last_stop;

  assign bit_end   = (baud_q == CNT_W'(CLKS_PER_BIT - 1));
  assign done_next = (baud_q == CNT_W'(CLKS_PER_BIT - 2));
  assign last_stop = (stop_q == 1'(STOP_BITS - 1));

  // Frame sequencer; tx is updated on the edge that enters each bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      stop_q  <= 1'b0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      rd_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      rd_q   <= 1'b0;
      done_q <= 1'b0;
      baud_q <= baud_q + CNT_W'(1);
      case (state_q)
        S_IDLE: begin
          baud_q <= '0;
          if (tx_en && !fifo_empty) begin
            state_q <= S_FETCH;
            rd_q    <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        S_FETCH: begin
          baud_q  <= '0;
          state_q <= S_LOAD;
        end
        S_LOAD: begin
          baud_q  <= '0;
          shift_q <= fifo_data;
          par_q   <= (^fifo_data) ^ 1'(PARITY_ODD);
          tx_q    <= 1'b0;
          state_q <= S_START;
        end
        S_START: begin
          if (bit_end) begin
            baud_q  <= '0;
            tx_q    <= shift_q[0];
            shift_q <= {1'b0, shift_q[7:1]};
            bit_q   <= '0;
            state_q <= S_DATA;
          end
        end
        S_DATA: begin
          if (bit_end) begin
            baud_q <= '0;
            if (bit_q == 3'd7) begin
              stop_q <= 1'b0;
              if (PARITY_EN != 0) begin
                tx_q    <= par_q;
                state_q <= S_PARITY;
              end else begin
                tx_q    <= 1'b1;
                state_q <= S_STOP;
              end
            end else begin
              tx_q    <= shift_q[0];
              shift_q <= {1'b0, shift_q[7:1]};
              bit_q   <= bit_q + 3'd1;
            end
          end
        end
        S_PARITY: begin
          if (bit_end) begin
            baud_q  <= '0;
            tx_q    <= 1'b1;
            stop_q  <= 1'b0;
            state_q <= S_STOP;
          end
        end
        S_STOP: begin
          // Raised one cycle early so the registered pulse lands on the final cycle.
          if (last_stop && done_next) done_q <= 1'b1;
          if (bit_end) begin
            baud_q <= '0;
            if (last_stop) begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end else begin
              stop_q <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
          baud_q  <= '0;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign fifo_rd_en = rd_q;
  assign tx         = tx_q;
  assign busy       = busy_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench: four transmitter configurations share one modelled FIFO.
module tb_fifo_uart_tx;

  localparam int unsigned CPB = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] tx_en = 4'b0000;
  logic       fifo_empty;
  logic [7:0] fifo_data = 8'h00;
  logic [3:0] tx_w, rd_w, busy_w, fd_w;

  int n_cmp = 0;
  int n_err = 0;
  int rd_cnt [4];
  int underflow = 0;
  logic [7:0] mem [8];
  int wr_ptr = 0;
  int rd_ptr = 0;

  always #5 clk = ~clk;

  assign fifo_empty = (wr_ptr == rd_ptr);

  fifo_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_base (
    .clk(clk), .rst(rst), .tx_en(tx_en[0]), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .fifo_rd_en(rd_w[0]), .tx(tx_w[0]), .busy(busy_w[0]), .frame_done(fd_w[0]));
  fifo_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_even (
    .clk(clk), .rst(rst), .tx_en(tx_en[1]), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .fifo_rd_en(rd_w[1]), .tx(tx_w[1]), .busy(busy_w[1]), .frame_done(fd_w[1]));
  fifo_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_odd (
    .clk(clk), .rst(rst), .tx_en(tx_en[2]), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .fifo_rd_en(rd_w[2]), .tx(tx_w[2]), .busy(busy_w[2]), .frame_done(fd_w[2]));
  fifo_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u_stop2 (
    .clk(clk), .rst(rst), .tx_en(tx_en[3]), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .fifo_rd_en(rd_w[3]), .tx(tx_w[3]), .busy(busy_w[3]), .frame_done(fd_w[3]));

  // FIFO model: data appears the cycle after a read strobe.
  always @(posedge clk) begin
    for (int s = 0; s < 4; s++) if (rd_w[s]) rd_cnt[s] <= rd_cnt[s] + 1;
    if (|rd_w) begin
      if (fifo_empty) underflow <= underflow + 1;
      else begin
        fifo_data <= mem[rd_ptr % 8];
        rd_ptr    <= rd_ptr + 1;
      end
    end
  end

  task automatic push(input logic [7:0] b);
    mem[wr_ptr % 8] = b;
    wr_ptr = wr_ptr + 1;
  endtask

  // seq holds the frame in transmit order, first bit in position nbits-1.
  task automatic check_frame(input int s, input logic [11:0] seq, input int nbits,
                             input int exp_gap, input string name);
    int gap;
    logic exp_bit;
    logic exp_fd;
    gap = 0;
    @(negedge clk);
    while (tx_w[s] === 1'b1 && gap < 300) begin
      gap++;
      @(negedge clk);
    end
    n_cmp++;
    if (gap >= 300) begin
      n_err++;
      $display("FAIL %s start: tx stayed %b, required 0 within 300 cycles", name, tx_w[s]);
      return;
    end
    if (exp_gap >= 0) begin
      n_cmp++;
      if (gap !== exp_gap) begin
        n_err++;
        $display("FAIL %s gap: got %0d idle cycles, required %0d", name, gap, exp_gap);
      end
    end
    for (int i = 0; i < nbits; i++) begin
      for (int j = 0; j < int'(CPB); j++) begin
        exp_bit = seq[nbits-1-i];
        exp_fd  = (i == nbits-1) && (j == int'(CPB)-1);
        n_cmp++;
        if (tx_w[s] !== exp_bit) begin
          n_err++;
          $display("FAIL %s tx bit %0d cyc %0d: got %b, required %b", name, i, j, tx_w[s], exp_bit);
        end
        n_cmp++;
        if (busy_w[s] !== 1'b1) begin
          n_err++;
          $display("FAIL %s busy bit %0d cyc %0d: got %b, required 1", name, i, j, busy_w[s]);
        end
        n_cmp++;
        if (fd_w[s] !== exp_fd) begin
          n_err++;
          $display("FAIL %s frame_done bit %0d cyc %0d: got %b, required %b", name, i, j, fd_w[s], exp_fd);
        end
        if (!exp_fd) @(negedge clk);
      end
    end
  endtask

  task automatic check_rd(input string name, input int got, input int req);
    n_cmp++;
    if (got !== req) begin
      n_err++;
      $display("FAIL %s rd pulses: got %0d, required %0d", name, got, req);
    end
  endtask

  task automatic test_reset();
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (c == 2) rst = 1'b0;
      n_cmp++;
      if (tx_w !== 4'hF || rd_w !== 4'h0 || busy_w !== 4'h0 || fd_w !== 4'h0) begin
        n_err++;
        $display("FAIL reset cyc %0d: tx=%b rd=%b busy=%b fd=%b, required 1111/0000/0000/0000",
                 c, tx_w, rd_w, busy_w, fd_w);
      end
    end
  endtask

  task automatic test_a5();
    int r0;
    r0 = rd_cnt[0];
    push(8'hA5);
    tx_en[0] = 1'b1;
    check_frame(0, 12'b0101001011, 10, -1, "a5");
    @(negedge clk);
    n_cmp++;
    if (tx_w[0] !== 1'b1 || busy_w[0] !== 1'b0) begin
      n_err++;
      $display("FAIL a5 idle: tx=%b busy=%b, required 1/0", tx_w[0], busy_w[0]);
    end
    tx_en[0] = 1'b0;
    check_rd("a5", rd_cnt[0] - r0, 1);
  endtask

  task automatic test_back_to_back();
    int r0;
    r0 = rd_cnt[0];
    push(8'h00);
    push(8'hFF);
    push(8'h3C);
    tx_en[0] = 1'b1;
    check_frame(0, 12'b0000000001, 10, -1, "b2b_00");
    check_frame(0, 12'b0111111111, 10, 3, "b2b_ff");
    check_frame(0, 12'b0001111001, 10, 3, "b2b_3c");
    tx_en[0] = 1'b0;
    repeat (3) @(negedge clk);
    check_rd("b2b", rd_cnt[0] - r0, 3);
    n_cmp++;
    if (underflow !== 0) begin
      n_err++;
      $display("FAIL b2b underflow: got %0d, required 0", underflow);
    end
  endtask

  task automatic test_no_read();
    int r0;
    r0 = rd_cnt[0];
    tx_en[0] = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      n_cmp++;
      if (rd_w[0] !== 1'b0 || tx_w[0] !== 1'b1) begin
        n_err++;
        $display("FAIL empty cyc %0d: rd=%b tx=%b, required 0/1", c, rd_w[0], tx_w[0]);
      end
    end
    tx_en[0] = 1'b0;
    push(8'h01);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      n_cmp++;
      if (rd_w !== 4'h0 || tx_w !== 4'hF) begin
        n_err++;
        $display("FAIL disabled cyc %0d: rd=%b tx=%b, required 0000/1111", c, rd_w, tx_w);
      end
    end
    check_rd("no_read", rd_cnt[0] - r0, 0);
    n_cmp++;
    if (fifo_empty !== 1'b0) begin
      n_err++;
      $display("FAIL no_read fifo_empty: got %b, required 0", fifo_empty);
    end
  endtask

  task automatic test_parity();
    tx_en[1] = 1'b1;
    check_frame(1, 12'b01000000011, 11, -1, "even_01");
    tx_en[1] = 1'b0;
    repeat (3) @(negedge clk);
    push(8'hA5);
    tx_en[1] = 1'b1;
    check_frame(1, 12'b01010010101, 11, -1, "even_a5");
    tx_en[1] = 1'b0;
    repeat (3) @(negedge clk);
    push(8'hA5);
    tx_en[2] = 1'b1;
    check_frame(2, 12'b01010010111, 11, -1, "odd_a5");
    tx_en[2] = 1'b0;
    repeat (3) @(negedge clk);
    check_rd("even", rd_cnt[1], 2);
    check_rd("odd", rd_cnt[2], 1);
  endtask

  task automatic test_stop2();
    push(8'hA5);
    tx_en[3] = 1'b1;
    check_frame(3, 12'b01010010111, 11, -1, "stop2_a5");
    tx_en[3] = 1'b0;
    repeat (3) @(negedge clk);
    check_rd("stop2", rd_cnt[3], 1);
  endtask

  task automatic test_reset_mid();
    int r0;
    int w;
    push(8'h55);
    tx_en[0] = 1'b1;
    w = 0;
    @(negedge clk);
    while (tx_w[0] === 1'b1 && w < 50) begin
      w++;
      @(negedge clk);
    end
    repeat (4 + 3*CPB) @(negedge clk);
    n_cmp++;
    if (tx_w[0] !== 1'b0) begin
      n_err++;
      $display("FAIL mid bit3 of 55: tx=%b, required 0", tx_w[0]);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++;
    if (tx_w[0] !== 1'b1 || busy_w[0] !== 1'b0) begin
      n_err++;
      $display("FAIL mid after reset: tx=%b busy=%b, required 1/0", tx_w[0], busy_w[0]);
    end
    r0 = rd_cnt[0];
    repeat (20) @(negedge clk);
    check_rd("mid_no_reread", rd_cnt[0] - r0, 0);
    push(8'h81);
    check_frame(0, 12'b0100000011, 10, -1, "mid_81");
    tx_en[0] = 1'b0;
    repeat (3) @(negedge clk);
    check_rd("mid_81", rd_cnt[0] - r0, 1);
  endtask

  initial begin
    test_reset();
    test_a5();
    test_back_to_back();
    test_no_read();
    test_parity();
    test_stop2();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
